mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage.
- Takes the same 32-bit A/B operand pair from decode, selected by funct3 instead of ALUop.
- Returns one 32-bit result through a valid/ready handshake so the pipeline can stall on it.
- Uses one multi-cycle shift-add / restoring-divide datapath shared by all eight M-extension ops.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the in-flight op (pipeline kill).
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  input  32  rs1 operand; multiplicand or dividend.
- B  input  32  rs2 operand; multiplier or divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- Out  output  32  result.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, out_valid=0, Out=0, counter=0, all datapath registers 0. in_ready=1 once rst is released.
- States are IDLE, BUSY, FIX and DONE.
- in_ready is 1 only in IDLE; it is a pure decode of state.
- IDLE -> BUSY when in_valid is 1 at an edge (edge E0). At E0 the unit latches funct3, the operand signs per op and the operand magnitudes, and clears counter and accumulator. Signed handling per op:
  - MULHSU treats A as signed and B as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
  - All other ops treat both operands as signed.
- BUSY: one iteration per edge, E1..E32; the counter increments each edge. The last iteration moves the state to FIX.
  - Multiply: radix-2 shift-add on magnitudes into a 64-bit product.
  - Divide: restoring division on magnitudes producing a 32-bit quotient and remainder.
- FIX (edge E33) applies sign correction, loads Out and moves to DONE; out_valid=1 from E33.
  - Multiply sign: negate the 64-bit product if the operand signs differ. MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - Quotient sign: negate if the dividend and divisor signs differ.
  - Remainder sign: takes the dividend's sign.
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = A unmodified (REM and REMU).
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Both special cases are resolved in FIX. Latency is therefore fixed at 33 cycles for every op and operand.
- DONE: Out and out_valid hold stable while out_ready=0. When out_valid and out_ready are both 1 at an edge, the next state is IDLE, out_valid=0 and Out holds its last value.
- No back-to-back issue: a new request is accepted at the earliest one cycle after the result handshake.
- flush=1 at an edge: next state IDLE and out_valid=0 from any state; any result in flight or pending is discarded. flush has priority over in_valid and out_ready. Out is not cleared.
- in_valid is ignored outside IDLE. Operand inputs may change freely after E0.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge.

Test Plan:
- MUL A=7, B=0xFFFFFFFD (-3) -> out_valid rises exactly 33 cycles after accept; Out=0xFFFFFFEB.
- MULH A=B=0x80000000 -> 0x40000000.
- MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU A=100, B=7 -> 14. REMU A=100, B=7 -> 2.
- Special cases:
  - DIVU A=5, B=0 -> 0xFFFFFFFF.
  - REM A=5, B=0 -> 5.
  - DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
  - REM A=0x80000000, B=0xFFFFFFFF -> 0.
  - All four have latency 33.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> Out and out_valid stable and in_ready=0 throughout. Raise out_ready -> IDLE next edge; in_ready=1.
- Abort and reset: flush pulsed 10 cycles after accept -> out_valid never asserts; in_ready=1 on the next cycle; a following MUL 3*4 returns 12. Repeat with rst pulsed low mid-BUSY -> out_valid=0 and in_ready=1 once rst is released.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up in a final cycle (33-cycle latency).
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a transfer happens on any rising edge where valid and ready are
  // both 1; in_ready is high only in IDLE, out_valid only in DONE.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [2:0]         r_op;
  logic               r_a_neg;
  logic               r_b_neg;
  logic [WIDTH-1:0]   r_a_mag;
  logic [WIDTH-1:0]   r_b_mag;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_out;
  logic               r_out_valid;

  logic               w_sign_a;
  logic               w_sign_b;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_result;

  // MULHU/DIVU/REMU are fully unsigned; MULHSU has an unsigned B.
  assign w_sign_a = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
  assign w_sign_b = w_sign_a && (funct3 != 3'b010);
  assign w_a_neg  = w_sign_a & A[WIDTH-1];
  assign w_b_neg  = w_sign_b & B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (WIDTH'(0) - A) : A;
  assign w_b_mag  = w_b_neg ? (WIDTH'(0) - B) : B;

  // Multiply: r_b_mag shifts right as the multiplier, r_acc collects the product.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_b_mag[0] ? {1'b0, r_a_mag} : {(WIDTH+1){1'b0}});

  // Divide: r_a_mag shifts left as the dividend, r_acc holds {remainder, quotient}.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_a_mag[WIDTH-1]};
  assign w_rem_sub  = w_rem_sh - {1'b0, r_b_mag};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b_mag});
  assign w_rem_next = w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  always_comb begin
    w_prod   = (r_a_neg ^ r_b_neg) ? ((2*WIDTH)'(0) - r_acc) : r_acc;
    w_quo    = (r_a_neg ^ r_b_neg) ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    w_rem    = r_a_neg ? (WIDTH'(0) - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    w_result = '0;
    if (!r_op[2]) begin
      w_result = (r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    end else if (!r_op[1]) begin
      // A zero divisor must not pick up the dividend's sign.
      w_result = (r_b_mag == '0) ? '1 : w_quo;
    end else begin
      // Zero divisor leaves |A| as remainder, so the sign fix-up restores A.
      // The 0x80000000 / -1 case falls out of the magnitude path unchanged.
      w_result = w_rem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_a_neg     <= 1'b0;
      r_b_neg     <= 1'b0;
      r_a_mag     <= '0;
      r_b_mag     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state <= BUSY;
            r_op    <= funct3;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_a_mag <= w_a_mag;
            r_b_mag <= w_b_mag;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_op[2]) begin
            r_acc   <= {w_mul_sum, r_acc[WIDTH-1:1]};
            r_b_mag <= r_b_mag >> 1;
          end else begin
            r_acc   <= {w_rem_next, r_acc[WIDTH-2:0], w_ge};
            r_a_mag <= r_a_mag << 1;
          end
          if (r_cnt == LAST_ITER) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_out       <= w_result;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign Out         = r_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model plus hand-computed
// literal vectors, latency, backpressure, flush and mid-operation reset.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Out;
  logic [1:0]  dbg_state;

  int n_total;
  int n_pass;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  mul_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Out        (Out),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model written from the RV32M rules using wide signed arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Compare process: every accepted result is checked against the model.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", 32'h1, 32'h0);
      else check("model_result", Out, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    funct3   = op;
    A        = a;
    B        = b;
    exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    funct3   = 3'($urandom_range(0, 7));
    A        = $urandom;
    B        = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic has_lit, input logic [31:0] lit);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    check({name, "_latency"}, lat, 33);
    if (has_lit) check({name, "_out"}, Out, lit);
    @(posedge clk); #1;
  endtask

  vec_t lit_vecs[17] = '{
    '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{3'd5, 32'd100,       32'd7,         32'd14},
    '{3'd7, 32'd100,       32'd7,         32'd2},
    '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'd5,         32'd0,         32'd5},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB},
    '{3'd1, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF},
    '{3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
    '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD}
  };

  vec_t mdl_vecs[8] = '{
    '{3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0},
    '{3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0},
    '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
    '{3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0},
    '{3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0},
    '{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0},
    '{3'd6, 32'h8765_4321, 32'h0000_1234, 32'h0},
    '{3'd7, 32'h1234_5678, 32'h0000_0100, 32'h0}
  };

  initial begin
    int lat;
    int seen;
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    funct3    = 3'd0;
    A         = '0;
    B         = '0;

    #1;
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_out", Out, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("reset_in_ready", {31'h0, in_ready}, 32'h1);

    foreach (lit_vecs[i])
      run_op($sformatf("lit%0d", i), lit_vecs[i].op, lit_vecs[i].a, lit_vecs[i].b,
             1'b1, lit_vecs[i].exp);
    foreach (mdl_vecs[i])
      run_op($sformatf("mdl%0d", i), mdl_vecs[i].op, mdl_vecs[i].a, mdl_vecs[i].b,
             1'b0, 32'h0);

    // Backpressure: result held for 10 cycles, then released.
    out_ready = 1'b0;
    issue(3'd5, 32'd100, 32'd7);
    wait_valid(lat);
    check("bp_latency", lat, 33);
    check("bp_out", Out, 32'd14);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_valid%0d", k), {31'h0, out_valid}, 32'h1);
      check($sformatf("bp_hold_out%0d", k), Out, 32'd14);
      check($sformatf("bp_hold_in_ready%0d", k), {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'h0, out_valid}, 32'h0);
    check("bp_release_in_ready", {31'h0, in_ready}, 32'h1);
    check("bp_release_out_held", Out, 32'd14);

    // Flush while a result waits in DONE: discarded, Out keeps its value.
    out_ready = 1'b0;
    issue(3'd7, 32'd100, 32'd7);
    wait_valid(lat);
    check("fdone_out", Out, 32'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    check("fdone_valid", {31'h0, out_valid}, 32'h0);
    check("fdone_in_ready", {31'h0, in_ready}, 32'h1);
    check("fdone_out_kept", Out, 32'd2);
    out_ready = 1'b1;

    // Flush mid-BUSY: no result may appear.
    seen = 0;
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    repeat (9) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    check("flush_in_ready", {31'h0, in_ready}, 32'h1);
    check("flush_valid", {31'h0, out_valid}, 32'h0);
    // flush outranks a simultaneous request
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_beats_in_valid", {31'h0, in_ready}, 32'h1);
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", seen, 0);
    run_op("after_flush_mul", 3'd0, 32'd3, 32'd4, 1'b1, 32'd12);

    // Asynchronous reset mid-BUSY.
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst_valid", {31'h0, out_valid}, 32'h0);
    check("arst_out", Out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_in_ready", {31'h0, in_ready}, 32'h1);
    check("arst_valid_after", {31'h0, out_valid}, 32'h0);
    run_op("after_rst_mul", 3'd0, 32'd3, 32'd4, 1'b1, 32'd12);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
